// File: rtl/pe_seq_ctrl.sv
// pe_seq_ctrl: job sequencer for one PE MAC/round datapath.
// Latency: first beat to done = N*L beats + stall cycles + 1 (flush) + N (round) + 1 (drain).
// Backpressure: op_ready only in FEED, cfg_ready only in IDLE; results have no backpressure.
//
// Ports:
//   clk, rst_n          clock; asynchronous reset, active-high despite the _n name
//   cfg_valid/ready     job handshake; cfg_slots (N, 0 = 8), cfg_len (L, 0 = 2^LEN_W)
//   op_valid/ready      operand beats op_a/op_b, slot-inner order (beat = k*N + j)
//   pe_*                PE multiplier inputs, accumulate/round slot selects, round enable
//   pe_data_out         PE registered rounded output
//   res_valid/idx/data  one result per slot, one cycle after each round read
//   busy, done          not-idle flag; one-cycle completion pulse
module pe_seq_ctrl #(
  parameter int DW    = 16,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [2:0]       cfg_slots,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [DW-1:0]    op_a,
  input  logic [DW-1:0]    op_b,
  output logic [DW-1:0]    pe_data_in_1,
  output logic [DW-1:0]    pe_data_in_2,
  output logic [3:0]       pe_add_number,
  output logic [3:0]       pe_round_number,
  output logic             pe_rounder_en,
  input  logic [DW-1:0]    pe_data_out,
  output logic             res_valid,
  output logic [2:0]       res_idx,
  output logic [DW-1:0]    res_data,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FEED  = 3'd1,
    S_FLUSH = 3'd2,
    S_ROUND = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t           state_q;
  // N-1 and L-1 are stored so the "0 encodes max" cases fall out of the
  // natural wrap of the subtraction and never need an extra counter bit.
  logic [2:0]       n_m1_q;
  logic [LEN_W-1:0] l_m1_q;
  logic [2:0]       j_q;
  logic [LEN_W-1:0] k_q;
  logic [2:0]       r_q;
  logic [3:0]       add_q;
  logic             res_vld_q;
  logic [2:0]       res_idx_q;

  logic             beat;
  logic             j_wrap;
  logic             last_beat;
  logic [2:0]       j_d;
  logic [LEN_W-1:0] k_d;

  assign beat      = (state_q == S_FEED) && op_valid;
  assign j_wrap    = (j_q == n_m1_q);
  assign last_beat = beat && j_wrap && (k_q == l_m1_q);
  assign j_d       = j_wrap ? 3'd0 : j_q + 3'd1;
  assign k_d       = j_wrap ? k_q + LEN_W'(1) : k_q;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q   <= S_IDLE;
      n_m1_q    <= '0;
      l_m1_q    <= '0;
      j_q       <= '0;
      k_q       <= '0;
      r_q       <= '0;
      add_q     <= '0;
      res_vld_q <= 1'b0;
      res_idx_q <= '0;
    end else begin
      // Result strobe trails the round read by the PE's output register.
      res_vld_q <= (state_q == S_ROUND);
      res_idx_q <= (state_q == S_ROUND) ? r_q : 3'd0;

      case (state_q)
        S_IDLE: begin
          if (cfg_valid) begin
            n_m1_q  <= cfg_slots - 3'd1;
            l_m1_q  <= cfg_len - LEN_W'(1);
            j_q     <= '0;
            k_q     <= '0;
            r_q     <= '0;
            state_q <= S_FEED;
          end
        end
        S_FEED: begin
          if (beat) begin
            // Slot select lags the operands by one cycle to line up with
            // the PE product register; it is held through gap cycles.
            add_q <= {1'b0, j_q};
            j_q   <= j_d;
            k_q   <= k_d;
            if (last_beat) state_q <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          r_q     <= '0;
          state_q <= S_ROUND;
        end
        S_ROUND: begin
          if (r_q == n_m1_q) state_q <= S_DRAIN;
          else               r_q     <= r_q + 3'd1;
        end
        S_DRAIN: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cfg_ready       = (state_q == S_IDLE);
  assign op_ready        = (state_q == S_FEED);
  assign busy            = (state_q != S_IDLE);
  assign done            = (state_q == S_DRAIN);
  assign pe_data_in_1    = beat ? op_a : '0;
  assign pe_data_in_2    = beat ? op_b : '0;
  assign pe_add_number   = add_q;
  assign pe_rounder_en   = (state_q == S_ROUND);
  assign pe_round_number = (state_q == S_ROUND) ? {1'b0, r_q} : 4'd0;
  assign res_valid       = res_vld_q;
  assign res_idx         = res_idx_q;
  assign res_data        = res_vld_q ? pe_data_out : '0;

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// tb_pe_seq_ctrl: randomized and directed bench for pe_seq_ctrl with a behavioural PE.
// Latency: expected result/done cycles derived from the last accepted beat.
// Backpressure: bench drives gaps on op_valid; results are consumed unconditionally.
module tb_pe_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [2:0]  cfg_slots;
  logic [7:0]  cfg_len;
  logic        op_valid;
  logic        op_ready;
  logic [15:0] op_a, op_b;
  logic [15:0] pe_data_in_1, pe_data_in_2;
  logic [3:0]  pe_add_number, pe_round_number;
  logic        pe_rounder_en;
  logic [15:0] pe_data_out;
  logic        res_valid;
  logic [2:0]  res_idx;
  logic [15:0] res_data;
  logic        busy, done;

  pe_seq_ctrl #(.DW(16), .LEN_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_slots(cfg_slots), .cfg_len(cfg_len),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .pe_data_in_1(pe_data_in_1), .pe_data_in_2(pe_data_in_2),
    .pe_add_number(pe_add_number), .pe_round_number(pe_round_number),
    .pe_rounder_en(pe_rounder_en), .pe_data_out(pe_data_out),
    .res_valid(res_valid), .res_idx(res_idx), .res_data(res_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int done_cyc = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Q7.9 multiply and 16-bit saturation: the PE's arithmetic.
  function automatic longint qmul(input logic [15:0] a, input logic [15:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return (sa * sb) >>> 9;
  endfunction

  function automatic logic [15:0] sat16(input longint v);
    if (v > 32767)  return 16'h7fff;
    if (v < -32768) return 16'h8000;
    return v[15:0];
  endfunction

  // Behavioural PE: registered product, slot accumulators, registered rounder.
  longint      pe_prod_q;
  longint      pe_acc[16];
  logic [15:0] pe_out_q;

  always @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      pe_prod_q <= 0;
      for (int i = 0; i < 16; i++) pe_acc[i] <= 0;
      pe_out_q <= '0;
    end else begin
      pe_acc[pe_add_number] <= pe_acc[pe_add_number] + pe_prod_q;
      pe_prod_q <= qmul(pe_data_in_1, pe_data_in_2);
      if (pe_rounder_en) pe_out_q <= sat16(pe_acc[pe_round_number]);
    end
  end
  assign pe_data_out = pe_out_q;

  // Reference: per-slot sums of all accepted beats since the last reset.
  longint ref_acc[8];

  typedef struct {
    int          idx;
    logic [15:0] data;
    int          at;
  } exp_t;
  exp_t exp_q[$];

  logic [15:0] qa[$];
  logic [15:0] qb[$];

  always @(negedge clk) begin : mon
    exp_t e;
    if (res_valid) begin
      if (exp_q.size() == 0) check("res_unexpected", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("res_idx", res_idx, e.idx);
        check("res_data", res_data, e.data);
        check("res_cycle", cyc, e.at);
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (op_valid && !op_ready) begin
      check("pe_in1_not_feed", pe_data_in_1, 0);
      check("pe_in2_not_feed", pe_data_in_2, 0);
    end
  end

  task automatic clear_ref();
    for (int i = 0; i < 8; i++) ref_acc[i] = 0;
    exp_q.delete();
  endtask

  // Called at posedge+1; leaves at posedge+1 with the DUT back in IDLE.
  task automatic do_reset();
    rst_n = 1'b1;
    cfg_valid = 1'b0;
    op_valid = 1'b0;
    clear_ref();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
  endtask

  task automatic load_ops(input int cnt, input int mode);
    qa.delete();
    qb.delete();
    for (int i = 0; i < cnt; i++) begin
      if (mode == 0) begin
        qa.push_back(16'h0200);
        qb.push_back(16'h0002);
      end else begin
        qa.push_back(16'($urandom_range(0, 4095)) - 16'd2048);
        qb.push_back(16'($urandom_range(0, 4095)) - 16'd2048);
      end
    end
  endtask

  // gap < 0 selects random 0..2 idle cycles between beats.
  task automatic run_job(input logic [2:0] slots, input logic [7:0] len, input int gap);
    int n, l, g, dn0, last_c;
    bit ok;
    n = (slots == 0) ? 8 : int'(slots);
    l = (len == 0) ? 256 : int'(len);
    dn0 = done_cnt;
    last_c = 0;
    cfg_valid = 1'b1;
    cfg_slots = slots;
    cfg_len = len;
    @(negedge clk);
    check("cfg_ready_idle", cfg_ready, 1);
    @(posedge clk);
    #1 cfg_valid = 1'b0;
    for (int b = 0; b < n * l; b++) begin
      if (b > 0) begin
        g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
        repeat (g) begin
          op_valid = 1'b0;
          op_a = 16'($urandom);
          op_b = 16'($urandom);
          cfg_valid = 1'($urandom_range(0, 1));
          cfg_slots = 3'($urandom);
          cfg_len = 8'($urandom);
          @(negedge clk);
          check("pe_in1_gap", pe_data_in_1, 0);
          @(posedge clk);
          #1;
        end
      end
      op_valid = 1'b1;
      op_a = qa[b];
      op_b = qb[b];
      ok = 1'b0;
      for (int w = 0; w < 20; w++) begin
        @(negedge clk);
        if (op_ready) begin
          ok = 1'b1;
          break;
        end
        @(posedge clk);
        #1;
      end
      if (!ok) begin
        check("op_ready_timeout", 0, 1);
        op_valid = 1'b0;
        return;
      end
      check("pe_in1_beat", pe_data_in_1, op_a);
      check("pe_in2_beat", pe_data_in_2, op_b);
      ref_acc[b % n] += qmul(op_a, op_b);
      last_c = cyc;
      @(posedge clk);
      #1;
    end
    cfg_valid = 1'b0;
    // Operands offered outside FEED must never reach the PE.
    op_valid = 1'b1;
    op_a = 16'($urandom);
    op_b = 16'($urandom);
    for (int r = 0; r < n; r++) exp_q.push_back('{r, sat16(ref_acc[r]), last_c + 3 + r});
    ok = 1'b0;
    for (int w = 0; w < n + 10; w++) begin
      @(negedge clk);
      #1;
      if (done_cnt != dn0) begin
        ok = 1'b1;
        break;
      end
    end
    check("done_seen", ok, 1);
    if (ok) begin
      check("done_latency", done_cyc - last_c, n + 2);
      check("done_count", done_cnt - dn0, 1);
    end
    check("res_missing", exp_q.size(), 0);
    exp_q.delete();
    @(posedge clk);
    #1 op_valid = 1'b0;
  endtask

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog timeout cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int dn;
    rst_n = 1'b0;
    cfg_valid = 1'b0;
    cfg_slots = '0;
    cfg_len = '0;
    op_valid = 1'b0;
    op_a = '0;
    op_b = '0;
    clear_ref();
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("rst_cfg_ready", cfg_ready, 1);
    check("rst_op_ready", op_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_idx", res_idx, 0);
    check("rst_res_data", res_data, 0);
    check("rst_rounder_en", pe_rounder_en, 0);
    check("rst_round_num", pe_round_number, 0);
    check("rst_add_num", pe_add_number, 0);
    @(posedge clk);
    #1 rst_n = 1'b0;

    // Single slot, single element: 1.0 * 1.0.
    qa.delete(); qb.delete();
    qa.push_back(16'h0200); qb.push_back(16'h0200);
    run_job(3'd1, 8'd1, 0);

    // Two slots, two elements, then the same job again onto held content.
    do_reset();
    qa.delete(); qb.delete();
    qa.push_back(16'h0200); qb.push_back(16'h0400);
    qa.push_back(16'h0100); qb.push_back(16'h0200);
    qa.push_back(16'h0200); qb.push_back(16'h0200);
    qa.push_back(16'h0100); qb.push_back(16'h0100);
    run_job(3'd2, 8'd2, 0);
    run_job(3'd2, 8'd2, 0);

    // Same job with three idle cycles between beats.
    do_reset();
    run_job(3'd2, 8'd2, 3);

    // Maximum job: 8 slots x 256 elements.
    do_reset();
    load_ops(2048, 0);
    run_job(3'd0, 8'd0, 0);

    // Reset in the middle of FEED after three beats.
    do_reset();
    load_ops(4, 1);
    cfg_valid = 1'b1;
    cfg_slots = 3'd2;
    cfg_len = 8'd2;
    @(posedge clk);
    #1 cfg_valid = 1'b0;
    for (int b = 0; b < 3; b++) begin
      op_valid = 1'b1;
      op_a = qa[b];
      op_b = qb[b];
      @(posedge clk);
      #1;
    end
    dn = done_cnt;
    rst_n = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_cfg_ready", cfg_ready, 1);
    check("midrst_op_ready", op_ready, 0);
    clear_ref();
    op_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    check("midrst_no_done", done_cnt, dn);
    qa.delete(); qb.delete();
    qa.push_back(16'h0300); qb.push_back(16'h0200);
    run_job(3'd1, 8'd1, 0);

    // Random jobs accumulating onto each other without reset.
    do_reset();
    for (int t = 0; t < 6; t++) begin
      logic [2:0] s;
      logic [7:0] len;
      int n;
      s = 3'($urandom_range(0, 7));
      len = 8'($urandom_range(1, 5));
      n = (s == 0) ? 8 : int'(s);
      load_ops(n * int'(len), 1);
      run_job(s, len, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
